// File: rtl/addsub_reservation_station_pkg.sv
// Shared encodings for the add/sub reservation station:
// entry states and the ALU op codes it passes through.
package addsub_reservation_station_pkg;

    typedef enum logic [1:0] {
        RS_EMPTY = 2'd0,
        RS_WAIT  = 2'd1,
        RS_READY = 2'd2,
        RS_EXEC  = 2'd3
    } rs_state_t;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;

endpackage

// File: rtl/addsub_reservation_station_rs_entry.sv
// One reservation-station entry: state machine, operand V/Q
// registers and CDB snooping for pending operands and own tag.
module rs_entry
    import addsub_reservation_station_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int OWN_TAG = 1
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              alloc,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_vj,
    input  logic [TAG_W-1:0]  in_qj,
    input  logic [DATA_W-1:0] in_vk,
    input  logic [TAG_W-1:0]  in_qk,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              dispatch,
    output logic              is_empty,
    output logic              is_ready,
    output logic [1:0]        op,
    output logic [DATA_W-1:0] vj,
    output logic [DATA_W-1:0] vk
);

    localparam logic [TAG_W-1:0] TAG = TAG_W'(OWN_TAG);

    rs_state_t         state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] vj_q, vj_d, vk_q, vk_d;
    logic [TAG_W-1:0]  qj_q, qj_d, qk_q, qk_d;

    logic [DATA_W-1:0] vj_src, vk_src, vj_cap, vk_cap;
    logic [TAG_W-1:0]  qj_src, qk_src, qj_cap, qk_cap;
    logic              hit_j, hit_k;

    // During issue the incoming tags are snooped; otherwise the held ones.
    always_comb begin
        vj_src = alloc ? in_vj : vj_q;
        qj_src = alloc ? in_qj : qj_q;
        vk_src = alloc ? in_vk : vk_q;
        qk_src = alloc ? in_qk : qk_q;
        hit_j  = cdb_valid && (qj_src != '0) && (cdb_tag == qj_src);
        hit_k  = cdb_valid && (qk_src != '0) && (cdb_tag == qk_src);
        vj_cap = hit_j ? cdb_data : vj_src;
        qj_cap = hit_j ? '0 : qj_src;
        vk_cap = hit_k ? cdb_data : vk_src;
        qk_cap = hit_k ? '0 : qk_src;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        vj_d    = vj_q;
        qj_d    = qj_q;
        vk_d    = vk_q;
        qk_d    = qk_q;
        unique case (state_q)
            RS_EMPTY: begin
                if (alloc) begin
                    op_d    = in_op;
                    vj_d    = vj_cap;
                    qj_d    = qj_cap;
                    vk_d    = vk_cap;
                    qk_d    = qk_cap;
                    state_d = (qj_cap == '0 && qk_cap == '0)
                              ? RS_READY : RS_WAIT;
                end
            end
            RS_WAIT: begin
                vj_d = vj_cap;
                qj_d = qj_cap;
                vk_d = vk_cap;
                qk_d = qk_cap;
                if (qj_cap == '0 && qk_cap == '0)
                    state_d = RS_READY;
            end
            RS_READY: begin
                if (dispatch)
                    state_d = RS_EXEC;
            end
            RS_EXEC: begin
                if (cdb_valid && cdb_tag == TAG)
                    state_d = RS_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= RS_EMPTY;
            op_q    <= '0;
            vj_q    <= '0;
            qj_q    <= '0;
            vk_q    <= '0;
            qk_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            vj_q    <= vj_d;
            qj_q    <= qj_d;
            vk_q    <= vk_d;
            qk_q    <= qk_d;
        end
    end

    assign is_empty = (state_q == RS_EMPTY);
    assign is_ready = (state_q == RS_READY);
    assign op       = op_q;
    assign vj       = vj_q;
    assign vk       = vk_q;

endmodule

// File: rtl/addsub_reservation_station.sv
// Add/sub reservation station: allocation and dispatch priority
// encoders around N_ENT rs_entry instances, plus ALU output muxes.
module addsub_reservation_station
    import addsub_reservation_station_pkg::*;
#(
    parameter int N_ENT    = 3,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int TAG_BASE = 1
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              iss_valid,
    input  logic [1:0]        iss_op,
    input  logic [DATA_W-1:0] iss_vj,
    input  logic [TAG_W-1:0]  iss_qj,
    input  logic [DATA_W-1:0] iss_vk,
    input  logic [TAG_W-1:0]  iss_qk,
    output logic              iss_ready,
    output logic [TAG_W-1:0]  iss_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              alu_avail,
    output logic              alu_wen,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] alu_data1,
    output logic [DATA_W-1:0] alu_data2,
    output logic [TAG_W-1:0]  alu_label
);

    localparam int IDX_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;

    logic [N_ENT-1:0]  empty, ready, alloc, dispatch;
    logic [1:0]        ent_op [N_ENT];
    logic [DATA_W-1:0] ent_vj [N_ENT];
    logic [DATA_W-1:0] ent_vk [N_ENT];

    logic [IDX_W-1:0]  alloc_idx, pick_idx, sel_idx, lock_idx_q;
    logic              lock_q;

    for (genvar g = 0; g < N_ENT; g++) begin : gen_ent
        rs_entry #(
            .DATA_W  (DATA_W),
            .TAG_W   (TAG_W),
            .OWN_TAG (TAG_BASE + g)
        ) u_ent (
            .clk       (clk),
            .nRST      (nRST),
            .alloc     (alloc[g]),
            .in_op     (iss_op),
            .in_vj     (iss_vj),
            .in_qj     (iss_qj),
            .in_vk     (iss_vk),
            .in_qk     (iss_qk),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_data  (cdb_data),
            .dispatch  (dispatch[g]),
            .is_empty  (empty[g]),
            .is_ready  (ready[g]),
            .op        (ent_op[g]),
            .vj        (ent_vj[g]),
            .vk        (ent_vk[g])
        );
    end

    always_comb begin
        alloc_idx = '0;
        pick_idx  = '0;
        for (int i = N_ENT - 1; i >= 0; i--) begin
            if (empty[i]) alloc_idx = IDX_W'(i);
            if (ready[i]) pick_idx  = IDX_W'(i);
        end
    end

    // A stalled dispatch keeps its entry even if a lower one turns ready.
    assign sel_idx   = lock_q ? lock_idx_q : pick_idx;
    assign iss_ready = |empty;
    assign iss_tag   = TAG_W'(TAG_BASE) + TAG_W'(alloc_idx);
    assign alu_wen   = |ready;

    always_comb begin
        alloc     = '0;
        dispatch  = '0;
        alu_op    = '0;
        alu_data1 = '0;
        alu_data2 = '0;
        alu_label = '0;
        for (int i = 0; i < N_ENT; i++) begin
            if (iss_valid && iss_ready && alloc_idx == IDX_W'(i))
                alloc[i] = 1'b1;
            if (alu_wen && sel_idx == IDX_W'(i)) begin
                dispatch[i] = alu_avail;
                alu_op      = ent_op[i];
                alu_data1   = ent_vj[i];
                alu_data2   = ent_vk[i];
                alu_label   = TAG_W'(TAG_BASE + i);
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= alu_wen && !alu_avail;
            lock_idx_q <= sel_idx;
        end
    end

endmodule

// File: tb/tb_addsub_reservation_station.sv
// Directed bench for addsub_reservation_station (3 entries, tags 1..3).
module tb_addsub_reservation_station;
    import addsub_reservation_station_pkg::*;

    logic        clk;
    logic        nRST;
    logic        iss_valid;
    logic [1:0]  iss_op;
    logic [31:0] iss_vj;
    logic [3:0]  iss_qj;
    logic [31:0] iss_vk;
    logic [3:0]  iss_qk;
    logic        iss_ready;
    logic [3:0]  iss_tag;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        alu_avail;
    logic        alu_wen;
    logic [1:0]  alu_op;
    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic [3:0]  alu_label;

    int total = 0;
    int bad   = 0;

    addsub_reservation_station dut (
        .clk       (clk),
        .nRST      (nRST),
        .iss_valid (iss_valid),
        .iss_op    (iss_op),
        .iss_vj    (iss_vj),
        .iss_qj    (iss_qj),
        .iss_vk    (iss_vk),
        .iss_qk    (iss_qk),
        .iss_ready (iss_ready),
        .iss_tag   (iss_tag),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .alu_avail (alu_avail),
        .alu_wen   (alu_wen),
        .alu_op    (alu_op),
        .alu_data1 (alu_data1),
        .alu_data2 (alu_data2),
        .alu_label (alu_label)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] vj,
                         input logic [3:0] qj, input logic [31:0] vk,
                         input logic [3:0] qk);
        iss_valid = 1'b1;
        iss_op    = op;
        iss_vj    = vj;
        iss_qj    = qj;
        iss_vk    = vk;
        iss_qk    = qk;
    endtask

    task automatic no_issue();
        iss_valid = 1'b0;
        iss_op    = '0;
        iss_vj    = '0;
        iss_qj    = '0;
        iss_vk    = '0;
        iss_qk    = '0;
    endtask

    task automatic cdb(input logic v, input logic [3:0] t,
                       input logic [31:0] d);
        cdb_valid = v;
        cdb_tag   = t;
        cdb_data  = d;
    endtask

    initial begin
        nRST = 1'b0;
        alu_avail = 1'b0;
        no_issue();
        cdb(1'b0, 4'd0, 32'd0);
        tick();
        tick();
        chk("rst_ready", {31'd0, iss_ready}, 32'd1);
        chk("rst_tag",   {28'd0, iss_tag},   32'd1);
        chk("rst_wen",   {31'd0, alu_wen},   32'd0);
        chk("rst_op",    {30'd0, alu_op},    32'd0);
        chk("rst_d1",    alu_data1,          32'd0);
        chk("rst_d2",    alu_data2,          32'd0);
        chk("rst_label", {28'd0, alu_label}, 32'd0);
        nRST = 1'b1;
        tick();

        // ready issue, dispatch, free
        alu_avail = 1'b1;
        issue(ALU_ADD, 32'd5, 4'd0, 32'd7, 4'd0);
        tick();
        no_issue();
        chk("t2_wen",   {31'd0, alu_wen},   32'd1);
        chk("t2_d1",    alu_data1,          32'd5);
        chk("t2_d2",    alu_data2,          32'd7);
        chk("t2_label", {28'd0, alu_label}, 32'd1);
        chk("t2_op",    {30'd0, alu_op},    {30'd0, ALU_ADD});
        chk("t2_itag",  {28'd0, iss_tag},   32'd2);
        tick();
        chk("t2_exec_wen", {31'd0, alu_wen}, 32'd0);
        chk("t2_exec_tag", {28'd0, iss_tag}, 32'd2);
        cdb(1'b1, 4'd1, 32'd99);
        tick();
        cdb(1'b0, 4'd0, 32'd0);
        chk("t2_free_tag", {28'd0, iss_tag}, 32'd1);

        // dependency on tag 3
        issue(ALU_SUB, 32'd0, 4'd3, 32'd2, 4'd0);
        tick();
        no_issue();
        chk("t3_wait_wen", {31'd0, alu_wen}, 32'd0);
        chk("t3_wait_tag", {28'd0, iss_tag}, 32'd2);
        cdb(1'b1, 4'd3, 32'd10);
        tick();
        cdb(1'b0, 4'd0, 32'd0);
        chk("t3_wen",   {31'd0, alu_wen},   32'd1);
        chk("t3_d1",    alu_data1,          32'd10);
        chk("t3_d2",    alu_data2,          32'd2);
        chk("t3_op",    {30'd0, alu_op},    {30'd0, ALU_SUB});
        chk("t3_label", {28'd0, alu_label}, 32'd1);
        tick();
        cdb(1'b1, 4'd1, 32'd0);
        tick();
        cdb(1'b0, 4'd0, 32'd0);
        chk("t3_free", {28'd0, iss_tag}, 32'd1);

        // same-cycle CDB capture at issue
        issue(ALU_ADD, 32'd4, 4'd0, 32'd0, 4'd3);
        cdb(1'b1, 4'd3, 32'hFFFF_FFFF);
        tick();
        no_issue();
        cdb(1'b0, 4'd0, 32'd0);
        chk("t4_wen", {31'd0, alu_wen}, 32'd1);
        chk("t4_d1",  alu_data1,        32'd4);
        chk("t4_d2",  alu_data2,        32'hFFFF_FFFF);
        tick();
        cdb(1'b1, 4'd1, 32'd0);
        tick();
        cdb(1'b0, 4'd0, 32'd0);
        chk("t4_free", {28'd0, iss_tag}, 32'd1);

        // fill with backpressure
        alu_avail = 1'b0;
        issue(ALU_ADD, 32'd1, 4'd0, 32'd2, 4'd0);
        tick();
        issue(ALU_SUB, 32'd3, 4'd0, 32'd4, 4'd0);
        tick();
        issue(ALU_ADD, 32'd5, 4'd0, 32'd6, 4'd0);
        tick();
        chk("t5_full",  {31'd0, iss_ready}, 32'd0);
        chk("t5_label", {28'd0, alu_label}, 32'd1);
        chk("t5_d1",    alu_data1,          32'd1);
        issue(ALU_SUB, 32'd9, 4'd0, 32'd9, 4'd0);
        tick();
        no_issue();
        chk("t5_full2",   {31'd0, iss_ready}, 32'd0);
        chk("t5_hold_lb", {28'd0, alu_label}, 32'd1);
        chk("t5_hold_d2", alu_data2,          32'd2);
        tick();
        chk("t5_hold_d1", alu_data1,          32'd1);
        alu_avail = 1'b1;
        tick();
        chk("t5_seq1_lb", {28'd0, alu_label}, 32'd2);
        chk("t5_seq1_d1", alu_data1,          32'd3);
        chk("t5_seq1_op", {30'd0, alu_op},    {30'd0, ALU_SUB});
        tick();
        chk("t5_seq2_lb", {28'd0, alu_label}, 32'd3);
        chk("t5_seq2_d2", alu_data2,          32'd6);
        tick();
        chk("t5_seq3_wen", {31'd0, alu_wen},  32'd0);
        chk("t5_seq3_rdy", {31'd0, iss_ready}, 32'd0);
        cdb(1'b1, 4'd1, 32'd0);
        tick();
        cdb(1'b1, 4'd2, 32'd0);
        tick();
        cdb(1'b1, 4'd3, 32'd0);
        tick();
        cdb(1'b0, 4'd0, 32'd0);
        chk("t5_drained", {28'd0, iss_tag}, 32'd1);
        chk("t5_nowen",   {31'd0, alu_wen}, 32'd0);

        // simultaneous dispatch, issue and free
        alu_avail = 1'b0;
        issue(ALU_ADD, 32'h11, 4'd0, 32'h22, 4'd0);
        tick();
        alu_avail = 1'b1;
        issue(ALU_SUB, 32'h33, 4'd0, 32'h44, 4'd0);
        tick();
        no_issue();
        chk("t6_pre_lb",  {28'd0, alu_label}, 32'd2);
        chk("t6_pre_tag", {28'd0, iss_tag},   32'd3);
        issue(ALU_ADD, 32'h55, 4'd0, 32'h66, 4'd0);
        cdb(1'b1, 4'd1, 32'd0);
        tick();
        no_issue();
        cdb(1'b0, 4'd0, 32'd0);
        chk("t6_tag",  {28'd0, iss_tag},   32'd1);
        chk("t6_rdy",  {31'd0, iss_ready}, 32'd1);
        chk("t6_lb",   {28'd0, alu_label}, 32'd3);
        chk("t6_d1",   alu_data1,          32'h55);

        // reset with entries in WAIT and EXEC
        issue(ALU_SUB, 32'd0, 4'd7, 32'd1, 4'd0);
        tick();
        no_issue();
        chk("t1_pre_rdy", {31'd0, iss_ready}, 32'd0);
        chk("t1_pre_wen", {31'd0, alu_wen},   32'd0);
        #2;
        nRST = 1'b0;
        #1;
        chk("t1_rdy", {31'd0, iss_ready}, 32'd1);
        chk("t1_tag", {28'd0, iss_tag},   32'd1);
        chk("t1_wen", {31'd0, alu_wen},   32'd0);
        #1;
        nRST = 1'b1;
        cdb(1'b1, 4'd2, 32'd0);
        tick();
        cdb(1'b1, 4'd7, 32'd0);
        tick();
        cdb(1'b0, 4'd0, 32'd0);
        chk("t1_post_rdy", {31'd0, iss_ready}, 32'd1);
        chk("t1_post_tag", {28'd0, iss_tag},   32'd1);
        chk("t1_post_wen", {31'd0, alu_wen},   32'd0);
        issue(ALU_ADD, 32'hA, 4'd0, 32'hB, 4'd0);
        tick();
        no_issue();
        chk("t1_new_lb", {28'd0, alu_label}, 32'd1);
        chk("t1_new_d1", alu_data1,          32'hA);
        chk("t1_new_tg", {28'd0, iss_tag},   32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
